arb_req_queue: RTL and testbench

- Request front-end that sits directly upstream of the 4-way round-robin arbiter.
- Each requester lane pushes payload words into a private FIFO. The block drives the arbiter's req vector from FIFO non-empty status.
- It pops the granted lane's head entry when gnt returns, and presents the granted payload and lane id, registered, to the downstream consumer.
- Catches illegal grants (non-one-hot, or a grant to an empty lane) with a sticky error flag.

---
 rtl/arb_req_queue_if.sv | 31 +++
 rtl/arb_req_queue.sv | 117 +++++++++++
 tb/tb_arb_req_queue.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/arb_req_queue_if.sv
// Bundle of the lane-push, arbiter req/gnt and granted-output signals of arb_req_queue.
// The slave modport is the queue block itself; master is whatever drives lanes and the arbiter.
interface arb_req_queue_if #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [N-1:0]      in_valid;
  logic [N*DW-1:0]   in_data;
  logic [N-1:0]      in_ready;
  logic [N-1:0]      req;
  logic [N-1:0]      gnt;
  logic              out_valid;
  logic [IW-1:0]     out_id;
  logic [DW-1:0]     out_data;
  logic [N*CW-1:0]   count;
  logic              gnt_err;

  modport slave (
    input  in_valid, in_data, gnt,
    output in_ready, req, out_valid, out_id, out_data, count, gnt_err
  );

  modport master (
    output in_valid, in_data, gnt,
    input  in_ready, req, out_valid, out_id, out_data, count, gnt_err
  );
endinterface

// File: rtl/arb_req_queue.sv
// Per-lane request FIFOs in front of an N-way arbiter: req from occupancy, pop on a legal
// one-hot grant, granted payload registered to the consumer, sticky flag on illegal grants.
module arb_req_queue #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  arb_req_queue_if.slave        bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [DW-1:0] mem_q   [N][DEPTH];
  logic [DW-1:0] mem_d   [N][DEPTH];
  logic [AW-1:0] wptr_q  [N];
  logic [AW-1:0] wptr_d  [N];
  logic [AW-1:0] rptr_q  [N];
  logic [AW-1:0] rptr_d  [N];
  logic [CW-1:0] cnt_q   [N];
  logic [CW-1:0] cnt_d   [N];

  logic          out_valid_q, out_valid_d;
  logic [IW-1:0] out_id_q,    out_id_d;
  logic [DW-1:0] out_data_q,  out_data_d;
  logic          gnt_err_q,   gnt_err_d;

  logic [N-1:0]    in_ready_c;
  logic [N-1:0]    req_c;
  logic [N-1:0]    push_c;
  logic [N-1:0]    pop_c;
  logic            gnt_legal_c;
  logic [N*CW-1:0] count_c;

  // Handshakes: a lane push completes on a posedge with in_valid[i] && in_ready[i];
  // in_ready and req come only from registered counts, so a slot freed by a same-cycle
  // pop is not reusable until the next cycle. The output side has no ready: every
  // out_valid cycle is consumed.
  always_comb begin
    in_ready_c = '0;
    req_c      = '0;
    count_c    = '0;
    for (int i = 0; i < N; i++) begin
      in_ready_c[i]          = !rst && (cnt_q[i] < CW'(DEPTH));
      req_c[i]               = (cnt_q[i] != '0);
      count_c[i*CW +: CW]    = cnt_q[i];
    end
    gnt_legal_c = (bus.gnt == '0) || ($onehot(bus.gnt) && ((bus.gnt & ~req_c) == '0));
    push_c      = bus.in_valid & in_ready_c;
    pop_c       = gnt_legal_c ? bus.gnt : '0;
  end

  always_comb begin
    mem_d       = mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_id_d    = out_id_q;
    out_data_d  = out_data_q;
    gnt_err_d   = gnt_err_q | !gnt_legal_c;
    for (int i = 0; i < N; i++) begin
      if (push_c[i]) begin
        mem_d[i][wptr_q[i]] = bus.in_data[i*DW +: DW];
        wptr_d[i]           = wptr_q[i] + AW'(1);
      end
      if (pop_c[i]) begin
        rptr_d[i]   = rptr_q[i] + AW'(1);
        out_valid_d = 1'b1;
        out_id_d    = IW'(i);
        out_data_d  = mem_q[i][rptr_q[i]];
      end
      case ({push_c[i], pop_c[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
      gnt_err_q   <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_data_q  <= out_data_d;
      gnt_err_q   <= gnt_err_d;
    end
  end

  // Storage needs no reset: entries are only visible through pointers, which do reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.req       = req_c;
  assign bus.count     = count_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_data  = out_data_q;
  assign bus.gnt_err   = gnt_err_q;
endmodule

// File: tb/tb_arb_req_queue.sv
// Bench for arb_req_queue: directed scenarios plus random traffic, checked against a
// queue-based lane model; a negedge monitor pops expected grants and compares all outputs.
module tb_arb_req_queue;
  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int IW    = 2;
  localparam int CW    = 3;
  localparam int W     = IW + DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arb_req_queue_if #(.N(N), .DW(DW), .DEPTH(DEPTH)) bus ();

  arb_req_queue #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: one queue per lane, sticky error bit, expected-output queue.
  logic [DW-1:0] lane_q [N][$];
  logic          model_err = 1'b0;
  logic [W-1:0]  exp_q[$];
  bit            chk_en = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the pre-edge lane contents.
  task automatic model_edge(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                            input logic [N-1:0] g, input logic r);
    int ones;
    int lane;
    bit can_push [N];
    if (r) begin
      for (int i = 0; i < N; i++) lane_q[i].delete();
      model_err = 1'b0;
      return;
    end
    ones = 0;
    lane = 0;
    for (int i = 0; i < N; i++) begin
      can_push[i] = (lane_q[i].size() < DEPTH);
      if (g[i]) begin
        ones++;
        lane = i;
      end
    end
    if (ones > 1 || (ones == 1 && lane_q[lane].size() == 0)) begin
      model_err = 1'b1;
    end else if (ones == 1) begin
      exp_q.push_back({IW'(lane), lane_q[lane].pop_front()});
    end
    for (int i = 0; i < N; i++)
      if (v[i] && can_push[i]) lane_q[i].push_back(d[i*DW +: DW]);
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                      input logic [N-1:0] g, input logic r);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.gnt      = g;
    rst          = r;
    @(posedge clk);
    model_edge(v, d, g, r);
    #1;
  endtask

  function automatic logic [N*DW-1:0] on_lane(input int lane, input logic [DW-1:0] val);
    logic [N*DW-1:0] x;
    x = '0;
    x[lane*DW +: DW] = val;
    return x;
  endfunction

  // Monitor: outputs are registered, so the model state after the last edge predicts them.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [W-1:0] e;
      check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (bus.out_valid) begin
          check("out_id", 32'(bus.out_id), 32'(e[W-1 -: IW]));
          check("out_data", 32'(bus.out_data), 32'(e[DW-1:0]));
        end
      end
      for (int i = 0; i < N; i++) begin
        check($sformatf("count%0d", i), 32'(bus.count[i*CW +: CW]), 32'(lane_q[i].size()));
        check($sformatf("req%0d", i), 32'(bus.req[i]), 32'(lane_q[i].size() != 0));
        check($sformatf("in_ready%0d", i), 32'(bus.in_ready[i]),
              32'(!rst && lane_q[i].size() < DEPTH));
      end
      check("gnt_err", 32'(bus.gnt_err), 32'(model_err));
    end
  end

  initial begin
    logic [N-1:0] g;
    int sel;
    int lane;
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.gnt      = '0;
    step('0, '0, '0, 1'b1);
    step('0, '0, '0, 1'b1);
    chk_en = 1'b1;

    // Single push then grant on lane 0.
    step(4'b0001, on_lane(0, 8'hA1), '0, 1'b0);
    step('0, '0, 4'b0001, 1'b0);
    step('0, '0, '0, 1'b0);

    // Fill lane 2, attempt a fifth push, then drain in order.
    step(4'b0100, on_lane(2, 8'h11), '0, 1'b0);
    step(4'b0100, on_lane(2, 8'h22), '0, 1'b0);
    step(4'b0100, on_lane(2, 8'h33), '0, 1'b0);
    step(4'b0100, on_lane(2, 8'h44), '0, 1'b0);
    step(4'b0100, on_lane(2, 8'h55), '0, 1'b0);
    for (int k = 0; k < 4; k++) step('0, '0, 4'b0100, 1'b0);
    step('0, '0, '0, 1'b0);

    // Full lane 1: pop with refused push, then simultaneous push and pop.
    for (int k = 0; k < 4; k++) step(4'b0010, on_lane(1, 8'(8'h60 + k)), '0, 1'b0);
    step(4'b0010, on_lane(1, 8'h6E), 4'b0010, 1'b0);
    step(4'b0010, on_lane(1, 8'h6F), 4'b0010, 1'b0);
    for (int k = 0; k < 3; k++) step('0, '0, 4'b0010, 1'b0);
    step('0, '0, '0, 1'b0);

    // Illegal grants: two-hot, then a grant to an empty lane; flag stays sticky.
    step(4'b1001, on_lane(0, 8'hC0) | on_lane(3, 8'hC3), '0, 1'b0);
    step('0, '0, 4'b1001, 1'b0);
    step('0, '0, 4'b0100, 1'b0);
    step('0, '0, '0, 1'b0);
    step('0, '0, 4'b0001, 1'b0);
    step('0, '0, '0, 1'b0);
    step('0, '0, '0, 1'b1);

    // Load all lanes, grant round-robin on consecutive cycles.
    step(4'b1111, {8'hB3, 8'hB2, 8'hB1, 8'hB0}, '0, 1'b0);
    step('0, '0, 4'b0001, 1'b0);
    step('0, '0, 4'b0010, 1'b0);
    step('0, '0, 4'b0100, 1'b0);
    step('0, '0, 4'b1000, 1'b0);
    step('0, '0, '0, 1'b0);

    // Reset with lanes partly full and a grant pending.
    step(4'b0101, {8'h00, 8'hD2, 8'h00, 8'hD0}, '0, 1'b0);
    step(4'b0011, {8'h00, 8'h00, 8'hE1, 8'hE0}, '0, 1'b0);
    step('0, '0, 4'b0001, 1'b1);
    step('0, '0, '0, 1'b0);

    // Random traffic: mostly legal grants, occasional illegal grants and resets.
    for (int k = 0; k < 3000; k++) begin
      sel = $urandom_range(0, 99);
      g = '0;
      if (sel < 60) begin
        lane = $urandom_range(0, N - 1);
        if (lane_q[lane].size() != 0) g[lane] = 1'b1;
      end else if (sel < 63) begin
        g = 4'($urandom_range(1, 15));
      end
      step(4'($urandom_range(0, 15)), (N*DW)'($urandom), g, ($urandom_range(0, 99) < 2));
    end
    step('0, '0, '0, 1'b0);
    step('0, '0, '0, 1'b0);
    @(negedge clk);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
